// File: rtl/mem_stage.sv
// Memory-access pipeline stage: req/ack handshake with a multi-cycle data memory plus the MEM/WB register.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic             MemToReg,
    input  logic             RegWrite,
    input  logic [4:0]       Rd,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic [WIDTH-1:0] Db,
    output logic             dm_req,
    output logic             dm_we,
    output logic [WIDTH-1:0] dm_addr,
    output logic [WIDTH-1:0] dm_wdata,
    input  logic [WIDTH-1:0] dm_rdata,
    input  logic             dm_ack,
    output logic             mem_stall,
    output logic             RegWrite_out,
    output logic [4:0]       Rd_out,
    output logic [WIDTH-1:0] WBData_out,
    output logic             align_fault
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r, state_next_s;
    logic             access_s, start_s, mem_stall_s;
    logic             dm_req_r, dm_we_r;
    logic [WIDTH-1:0] dm_addr_r, dm_wdata_r, ld_buf_r;
    logic             reg_write_out_r;
    logic [4:0]       rd_out_r;
    logic [WIDTH-1:0] wb_data_out_r;

    assign access_s = MemWrite | MemToReg;

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned_s, fault_s, align_fault_r;
    assign misaligned_s = (ALUResult[2:0] != 3'd0);
    assign fault_s      = (state_r == ST_IDLE) && access_s && misaligned_s;
    assign start_s      = (state_r == ST_IDLE) && access_s && !misaligned_s;
    assign align_fault  = align_fault_r;

    // Fault pulse register: high for exactly the cycle after a trapped access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            align_fault_r <= 1'b0;
        end else begin
            align_fault_r <= fault_s;
        end
    end
`else
    assign start_s     = (state_r == ST_IDLE) && access_s;
    assign align_fault = 1'b0;
`endif

    // Controller state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; DONE exists so the held EX/MEM instruction is not re-issued
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (dm_ack) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode: stall covers the issuing IDLE cycle and every BUSY cycle
    always_comb begin
        mem_stall_s = 1'b0;
        case (state_r)
            ST_IDLE: mem_stall_s = start_s;
            ST_BUSY: mem_stall_s = 1'b1;
            ST_DONE: mem_stall_s = 1'b0;
            default: mem_stall_s = 1'b0;
        endcase
    end

    assign mem_stall = mem_stall_s;

    // Memory request registers; address/data/direction latched once at issue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dm_req_r   <= 1'b0;
            dm_we_r    <= 1'b0;
            dm_addr_r  <= {WIDTH{1'b0}};
            dm_wdata_r <= {WIDTH{1'b0}};
        end else begin
            dm_req_r <= (state_next_s == ST_BUSY);
            if (start_s) begin
                dm_we_r    <= MemWrite;
                dm_addr_r  <= ALUResult;
                dm_wdata_r <= Db;
            end
        end
    end

    // Load buffer captures read data only on a BUSY-state ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_buf_r <= {WIDTH{1'b0}};
        end else if ((state_r == ST_BUSY) && dm_ack) begin
            ld_buf_r <= dm_rdata;
        end
    end

    // MEM/WB register: bubble while stalled, otherwise forward the instruction result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_out_r <= 1'b0;
            rd_out_r        <= 5'd0;
            wb_data_out_r   <= {WIDTH{1'b0}};
        end else if (mem_stall_s) begin
            reg_write_out_r <= 1'b0;
            rd_out_r        <= 5'd0;
            wb_data_out_r   <= {WIDTH{1'b0}};
`ifdef MEM_ALIGN_CHECK_EN
        end else if (fault_s) begin
            reg_write_out_r <= 1'b0;
            rd_out_r        <= Rd;
            wb_data_out_r   <= ALUResult;
`endif
        end else begin
            reg_write_out_r <= RegWrite;
            rd_out_r        <= Rd;
            wb_data_out_r   <= MemToReg ? ld_buf_r : ALUResult;
        end
    end

    assign dm_req       = dm_req_r;
    assign dm_we        = dm_we_r;
    assign dm_addr      = dm_addr_r;
    assign dm_wdata     = dm_wdata_r;
    assign RegWrite_out = reg_write_out_r;
    assign Rd_out       = rd_out_r;
    assign WBData_out   = wb_data_out_r;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipelined datapath. It sits between the EX/MEM pipeline register and the register-file writeback. It takes the registered ALU result, store data and control bits, and runs each load or store as a req/ack handshake with a multi-cycle data memory. While a handshake is in progress it stalls the upstream pipeline. It also contains the MEM/WB register that presents writeback data, destination register and write enable to the WB stage.

## Interface
- WIDTH, 64, data and address width in bits.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- MemWrite  in  1  store request, from EX/MEM.
- MemToReg  in  1  load request (writeback takes memory data), from EX/MEM.
- RegWrite  in  1  register write enable, from EX/MEM.
- Rd  in  5  destination register, from EX/MEM.
- ALUResult  in  WIDTH  effective address for loads and stores; writeback value otherwise.
- Db  in  WIDTH  store data.
- dm_req  out  1  memory request; registered.
- dm_we  out  1  1 = write, 0 = read; registered.
- dm_addr  out  WIDTH  registered address.
- dm_wdata  out  WIDTH  registered store data.
- dm_rdata  in  WIDTH  read data; valid in the cycle where dm_ack=1.
- dm_ack  in  1  single-cycle completion pulse.
- mem_stall  out  1  combinational; 1 = hold EX/MEM and all earlier stages.
- RegWrite_out  out  1  MEM/WB write enable.
- Rd_out  out  5  MEM/WB destination register.
- WBData_out  out  WIDTH  MEM/WB writeback data.
- align_fault  out  1  registered single-cycle fault pulse (only when the macro is defined).

## Operation
- An instruction is an access when `access = MemWrite | MemToReg`. If both bits are 1, the block treats it as a store (`dm_we = 1`) and writeback still takes the memory read value `ld_buf`.
- The controller has three states: IDLE, BUSY, DONE.
  - IDLE, access=1: `mem_stall=1`. Latch `dm_addr=ALUResult`, `dm_wdata=Db`, `dm_we=MemWrite`. Go to BUSY.
  - IDLE, access=0: `mem_stall=0`. Stay in IDLE.
  - BUSY: `dm_req=1`, `mem_stall=1`; `dm_addr`, `dm_wdata` and `dm_we` stay stable. When `dm_ack=1`, capture `ld_buf=dm_rdata` and go to DONE. Otherwise stay in BUSY indefinitely.
  - DONE: `mem_stall=0`, `dm_req=0`. Go to IDLE.
- `dm_ack` is ignored in IDLE and DONE.
- The MEM/WB register updates every cycle:
  - If `mem_stall=1`, it loads a bubble: `RegWrite_out=0`, `Rd_out=0`, `WBData_out=0`.
  - Otherwise `RegWrite_out=RegWrite`, `Rd_out=Rd`, and `WBData_out = MemToReg ? ld_buf : ALUResult`.
- The DONE state ensures one access is issued exactly once, even though EX/MEM holds the same instruction for several cycles.
- A non-access instruction that follows an access (EX/MEM advances at the end of DONE) is evaluated in IDLE the next cycle with no gap.
- No width conversion is performed; all data paths are WIDTH bits.

## Timing
- Non-access instruction: zero added latency. It appears on the MEM/WB outputs at the next edge.
- Access with ack in the first BUSY cycle: `mem_stall` is high for 2 cycles (IDLE, BUSY). The MEM/WB outputs update at the end of the DONE cycle, 3 cycles after the instruction entered MEM.
- Each extra wait cycle before `dm_ack` adds one stall cycle.
- Reset values: state=IDLE; `dm_req`, `dm_we`, `dm_addr`, `dm_wdata`, `ld_buf`, `RegWrite_out`, `Rd_out`, `WBData_out`, `align_fault` all 0. `mem_stall` follows the inputs combinationally: with state=IDLE it equals `access`.
- Reset asserted during BUSY: `dm_req` drops asynchronously and the in-flight access is abandoned. A later `dm_ack` arriving in IDLE is ignored.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - In IDLE, an access with `ALUResult[2:0] != 0` issues no request and causes no stall; the state stays IDLE.
  - MEM/WB loads `RegWrite_out=0`, `Rd_out=Rd`, `WBData_out=ALUResult`.
  - `align_fault` pulses 1 for one cycle after the edge.
- `MEM_ALIGN_CHECK_EN` undefined: no alignment check; the address is passed to memory unchanged, and `align_fault` is tied to 0.

## Test plan
- ALU op, `RegWrite=1`, `Rd=5`, `ALUResult=0x2A`, no access -> next edge: `RegWrite_out=1`, `Rd_out=5`, `WBData_out=0x2A`; `mem_stall` never asserts.
- Load at `ALUResult=0x40`, `dm_ack` on the first BUSY cycle with `dm_rdata=0xDEADBEEF` -> `mem_stall` high exactly 2 cycles; bubble on MEM/WB during the stall; then `WBData_out=0xDEADBEEF` with `RegWrite_out=1`; exactly one `dm_req` episode with `dm_we=0`.
- Store of `Db=0x1234` to `0x80` with `dm_ack` delayed 4 cycles -> `dm_req`, `dm_we=1`, `dm_addr=0x80`, `dm_wdata=0x1234` held stable for 4 cycles; `mem_stall` high 5 cycles; `RegWrite_out=0`.
- Back-to-back load then ALU op -> the ALU result reaches MEM/WB on the edge right after the load's writeback; the load is not re-issued.
- Reset pulse during BUSY, then a stray `dm_ack` -> all outputs 0, state IDLE, `dm_ack` ignored, no writeback.
- With `MEM_ALIGN_CHECK_EN`: load at `0x43` -> no `dm_req`, `align_fault` one-cycle pulse, `RegWrite_out=0`.
